// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder shared across the datapath library.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: captures two operands, adds them LSB-first through one
// full_adder per clock, and hands the sum/carry out over a valid/ready port.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_sr, a_sr_nxt;
    logic [WIDTH-1:0]   b_sr, b_sr_nxt;
    logic [WIDTH-1:0]   sum_sr, sum_sr_nxt;
    logic               carry, carry_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   out_sum_nxt;
    logic               out_cout_nxt;
    logic               in_ready_nxt;
    logic               out_valid_nxt;
    logic               busy_nxt;
    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   sum_shifted;

    full_adder u_full_adder (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign sum_shifted = {fa_sum, sum_sr[WIDTH-1:1]};

    // Next-state and datapath sequencing.
    always_comb begin
        state_nxt    = state;
        a_sr_nxt     = a_sr;
        b_sr_nxt     = b_sr;
        sum_sr_nxt   = sum_sr;
        carry_nxt    = carry;
        cnt_nxt      = cnt;
        out_sum_nxt  = out_sum;
        out_cout_nxt = out_cout;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_sr_nxt  = in_a;
                    b_sr_nxt  = in_b;
                    carry_nxt = in_cin;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                sum_sr_nxt = sum_shifted;
                a_sr_nxt   = a_sr >> 1;
                b_sr_nxt   = b_sr >> 1;
                carry_nxt  = fa_cout;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    cnt_nxt      = '0;
                    out_sum_nxt  = sum_shifted;
                    out_cout_nxt = fa_cout;
                    state_nxt    = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Handshake flags are registered copies of the decoded next state.
        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);
        busy_nxt      = (state_nxt == RUN) || (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            a_sr      <= a_sr_nxt;
            b_sr      <= b_sr_nxt;
            sum_sr    <= sum_sr_nxt;
            carry     <= carry_nxt;
            cnt       <= cnt_nxt;
            out_sum   <= out_sum_nxt;
            out_cout  <= out_cout_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial adder built around the team's existing single-bit full_adder. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake, then adds them LSB-first, one bit per clock. It returns the WIDTH-bit sum and the carry-out through a second valid/ready handshake. The block is the sequencing stage that feeds full_adder operand bits and consumes its sum/cout every cycle; it is the area-cheap alternative to a WIDTH-wide ripple adder.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range is WIDTH >= 2.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands on in_a/in_b/in_cin are valid.
in_ready  output  1  block can accept operands; high only in IDLE.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_cin  input  1  carry-in.
out_valid  output  1  result on out_sum/out_cout is valid; high only in DONE.
out_ready  input  1  downstream accepts the result.
out_sum  output  WIDTH  registered sum, modulo 2^WIDTH.
out_cout  output  1  registered carry out of the MSB.
busy  output  1  high in RUN or DONE.

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high on rst. rst overrides all other inputs on the same edge.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0. All shift registers, the carry register and the bit counter are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture in_a into the A shift register, in_b into the B shift register, in_cin into the carry register, set bit counter=0, and go to RUN.
- RUN:
  - full_adder inputs are A_sr[0], B_sr[0] and the carry register.
  - Each edge: shift the full_adder sum into the sum shift register from the MSB side (shift right). Shift A_sr and B_sr right by one. Load the carry register with the full_adder cout. Increment the counter.
  - On the edge where counter==WIDTH-1: load out_sum with the completed sum (including this bit), load out_cout with the final cout, and go to DONE.
  - in_valid is ignored in RUN; operands are never re-captured.
- DONE:
  - out_valid=1; out_sum and out_cout are stable.
  - On an edge with out_ready=1, go to IDLE.
  - With out_ready=0, stay in DONE indefinitely with all outputs held.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge.
- Throughput: minimum WIDTH+2 edges per operation. There is no accept in the same cycle as a result handoff.
- Outputs outside DONE: out_sum/out_cout keep the last result until the next DONE entry. They are qualified only by out_valid.
- Arithmetic: out_sum = (in_a + in_b + in_cin) mod 2^WIDTH; out_cout = bit WIDTH of that sum.
- Reset mid-operation: rst in RUN or DONE discards the operation. All outputs take reset values on that edge, and no out_valid pulse occurs for the discarded operation.
- Bit counter width is $clog2(WIDTH); the counter saturates nowhere and only counts 0..WIDTH-1.

Decomposition:
- serial_adder_pkg: state enum typedef (IDLE, RUN, DONE).
- Counter width is derived locally from WIDTH.
- Sub-module: the existing full_adder (ports a, b, cin, sum, cout), instantiated exactly once. All bit arithmetic goes through it; no "+" operator is used in the datapath.

Test Plan:
1. Reset: hold rst for 2 cycles, then release -> in_ready=1, out_valid=0, busy=0, out_sum=0x00, out_cout=0.
2. WIDTH=8, a=0x3C, b=0x0F, cin=0 -> out_sum=0x4B, out_cout=0. out_valid rises exactly 8 edges after accept; busy is high throughout.
3. Carry and wrap:
   - a=0xFF, b=0x01, cin=0 -> out_sum=0x00, out_cout=1.
   - a=0xFF, b=0xFF, cin=1 -> out_sum=0xFF, out_cout=1.
   - a=0x00, b=0x00, cin=1 -> out_sum=0x01, out_cout=0.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands applied -> out_valid stays 1, out_sum is unchanged, in_ready=0, no capture. Raise out_ready -> IDLE next edge; the following accept uses the new operands.
5. Reset mid-RUN: assert rst after 3 RUN edges -> next edge in_ready=1, out_valid=0, out_sum=0. No result ever appears for that operation; the next operation a=0x12, b=0x34 -> 0x46, cout=0.
6. Operand stability: change in_a/in_b every cycle during RUN -> result matches only the operands captured at the accepting edge; run a random sweep of 200 operations against a reference model.
